// File: rtl/micro_sequencer.sv
// Microprogram sequencer: control address register, branch/dispatch logic
// and a return-address stack for microsubroutines.
module micro_sequencer #(
    parameter int unsigned UADDR_W     = 5,
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned FETCH_ADDR  = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [UADDR_W-1:0]        uaddr,
    input  logic [CTRL_W+5+UADDR_W-1:0] uword,
    input  logic [UADDR_W-1:0]        dispatch_addr,
    input  logic [3:0]                cond,
    input  logic                      stall,
    output logic [CTRL_W-1:0]         ctrl,
    output logic                      err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_JUMP  = 3'b001;
    localparam logic [2:0] OP_DISP  = 3'b010;
    localparam logic [2:0] OP_BR_T  = 3'b011;
    localparam logic [2:0] OP_BR_F  = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_FETCH = 3'b111;

    localparam logic [UADDR_W-1:0] FETCH_UA = UADDR_W'(FETCH_ADDR);
    localparam logic [UADDR_W-1:0] UA_ONE   = UADDR_W'(1);
    localparam logic [SP_W-1:0]    SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]    SP_ONE   = SP_W'(1);

    logic [UADDR_W-1:0] r_car;
    logic [SP_W-1:0]    r_sp;
    logic               r_err;
    logic [UADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [UADDR_W-1:0] w_next;
    logic [1:0]         w_cond_sel;
    logic [2:0]         w_seq_op;
    logic [UADDR_W-1:0] w_inc;
    logic               w_c;
    logic               w_full;
    logic               w_empty;
    logic [IDX_W-1:0]   w_push_idx;
    logic [IDX_W-1:0]   w_pop_idx;
    logic [UADDR_W-1:0] w_nxt_car;
    logic               w_push;
    logic               w_pop;
    logic               w_set_err;

    assign w_next     = uword[UADDR_W-1:0];
    assign w_cond_sel = uword[UADDR_W +: 2];
    assign w_seq_op   = uword[UADDR_W+2 +: 3];
    assign w_inc      = r_car + UA_ONE;
    assign w_c        = cond[w_cond_sel];
    assign w_full     = (r_sp == SP_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_ONE);

    // State register: CAR, stack pointer and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_car <= FETCH_UA;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (!stall) begin
            r_car <= w_nxt_car;
            if (w_push) begin
                r_sp <= r_sp + SP_ONE;
            end else if (w_pop) begin
                r_sp <= r_sp - SP_ONE;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stack contents need no reset; an empty pointer makes them unreachable
    always_ff @(posedge clk) begin
        if (!reset && !stall && w_push) begin
            r_stack[w_push_idx] <= w_inc;
        end
    end

    // Next-address selection
    always_comb begin
        w_nxt_car = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_err = 1'b0;
        case (w_seq_op)
            OP_NEXT:  w_nxt_car = w_inc;
            OP_JUMP:  w_nxt_car = w_next;
            OP_DISP:  w_nxt_car = dispatch_addr;
            OP_BR_T:  w_nxt_car = w_c ? w_next : w_inc;
            OP_BR_F:  w_nxt_car = w_c ? w_inc : w_next;
            OP_CALL: begin
                w_nxt_car = w_next;
                if (w_full) begin
                    w_set_err = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            OP_RET: begin
                if (w_empty) begin
                    w_nxt_car = FETCH_UA;
                    w_set_err = 1'b1;
                end else begin
                    w_nxt_car = r_stack[w_pop_idx];
                    w_pop     = 1'b1;
                end
            end
            OP_FETCH: w_nxt_car = FETCH_UA;
            default:  w_nxt_car = w_inc;
        endcase
    end

    // Outputs
    always_comb begin
        uaddr = r_car;
        ctrl  = uword[UADDR_W+5 +: CTRL_W];
        err   = r_err;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised microprogram sequencer: the next-generation successor of the fixed 5-bit-address, decode-only-dispatch controller core.
- Holds a registered control address register (CAR) and drives an external control-store ROM.
- Adds over the previous generation: increment, unconditional jump, conditional branches on selectable condition inputs, microsubroutine call/return via a return-address stack, stall, and a sticky error flag.
- Sits between the opcode decode / dispatch logic and the datapath control fields of the multicycle RISC-V core.

Parameters:
UADDR_W, 5, control-store address width (2^UADDR_W micro-words)
CTRL_W, 16, width of datapath control field in each micro-word
STACK_DEPTH, 4, return-address stack entries (>=1)
FETCH_ADDR, 30, micro-address of the Fetch micro-instruction; reset and FETCH target

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces CAR=FETCH_ADDR, stack empty, err=0
uaddr  out  UADDR_W  current CAR, drives control-store address
uword  in  CTRL_W+5+UADDR_W  micro-word read combinationally from the store at uaddr
dispatch_addr  in  UADDR_W  target from opcode dispatch table, valid during DISPATCH
cond  in  4  branch condition inputs (e.g. Zero, opcode flags)
stall  in  1  1 = hold all sequencer state this cycle
ctrl  out  CTRL_W  datapath control field, uword[UADDR_W+5 +: CTRL_W], combinational pass-through
err  out  1  sticky: stack overflow or underflow occurred

Behaviour:
- Micro-word fields, MSB to LSB: ctrl[CTRL_W], seq_op[3], cond_sel[2], next[UADDR_W].
- Reset values: CAR=FETCH_ADDR, stack pointer sp=0 (empty), err=0. ctrl follows uword at FETCH_ADDR.
- Registered next-address behaviour: the CAR register takes nextCAR on each rising edge when stall=0 and reset=0.
  - Latency: a micro-word at address A is presented during the cycle CAR=A.
  - Its successor is presented exactly one cycle later.
- Let inc = CAR+1 modulo 2^UADDR_W (wraps from all-ones to 0) and c = cond[cond_sel].
- seq_op encodings:
  - 000 NEXT: nextCAR=inc.
  - 001 JUMP: nextCAR=next.
  - 010 DISPATCH: nextCAR=dispatch_addr.
  - 011 BR_T: nextCAR = c ? next : inc.
  - 100 BR_F: nextCAR = c ? inc : next.
  - 101 CALL: push inc, nextCAR=next.
  - 110 RET: pop, nextCAR=popped value.
  - 111 FETCH: nextCAR=FETCH_ADDR.
- Stack: LIFO with push/pop on the same edge as the CAR update.
  - Full means sp=STACK_DEPTH.
- CALL when full:
  - Jump still taken; push dropped, sp unchanged.
  - err set.
- RET when empty:
  - nextCAR=FETCH_ADDR; sp stays 0.
  - err set.
- stall=1:
  - CAR, stack, sp and err all hold.
  - ctrl continues to reflect the current uword; masking of datapath write enables during stall is the datapath's responsibility.
- err is cleared only by reset.
- Reset asserted mid-sequence (any state, including inside a subroutine):
  - CAR goes to FETCH_ADDR immediately (asynchronously); stack is emptied.
  - First post-reset edge executes the FETCH_ADDR word.
- No X propagation: X-valued cond bits are not selected unless addressed by cond_sel; the implementation makes no assumption about unused fields.

Test Plan:
- Reset: hold reset 2 cycles, release -> uaddr=30, err=0; FETCH_ADDR word with seq_op=001, next=31 -> uaddr=31 next cycle.
- Dispatch: word at 31 seq_op=010, dispatch_addr=12 -> uaddr=12 next cycle; NEXT at 31 (inc=0 wrap) -> uaddr=0.
- Conditional: BR_T, cond_sel=0, next=24, cond=4'b0001 -> uaddr=24; same with cond=0 at CAR=5 -> uaddr=6; BR_F mirrors both.
- Call/return: CALL next=20 at CAR=10 -> uaddr=20; RET at 20 -> uaddr=11; nested 4 CALLs then 4 RETs -> return addresses popped in reverse order, err=0.
- Errors: 5th nested CALL -> jump taken, err=1; RET with empty stack -> uaddr=30, err stays 1 until reset.
- Stall: stall=1 for 3 cycles during CALL word -> uaddr, sp unchanged; release -> CALL executes once (single push).
